// File: rtl/datapath_pkg.sv
// Shared types for the datapath sequencer: micro-instruction layout, decoded
// control bundle, opcode and FSM state encodings.
package datapath_pkg;

  localparam int REG_AW_P      = 4;
  localparam int SEL_W_P       = 4;
  localparam int OUT_W_P       = 7;
  localparam int REP_W_P       = 2;
  localparam int CTRL_W        = 8;
  localparam int CTRL_WSRC_BIT = 0;

  typedef enum logic [2:0] {
    OP_SHR = 3'd1,
    OP_MOV = 3'd4
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [2:0]          op;
    logic                emit;
    logic                wen;
    logic                wsrc;
    logic [REG_AW_P-1:0] wa;
    logic [REG_AW_P-1:0] raa;
    logic [REG_AW_P-1:0] rab;
    logic [2:0]          sel;
    logic                cond;
    logic [REP_W_P-1:0]  rep;
  } instr_t;

  // Per-instruction fields held constant across all repetitions
  typedef struct packed {
    logic [2:0]          op;
    logic                emit;
    logic                wen;
    logic [REG_AW_P-1:0] wa;
    logic [REG_AW_P-1:0] raa;
    logic [REG_AW_P-1:0] rab;
    logic [SEL_W_P-1:0]  sel;
    logic [CTRL_W-1:0]   ctrl;
  } ctrl_t;

endpackage

// File: rtl/datapath_sequencer_instr_decode.sv
// Combinational decode of a micro-instruction word into the datapath control
// bundle plus the sequencing fields (cond, rep) used at acceptance.
module instr_decode
  import datapath_pkg::*;
(
  input  instr_t             instr,
  output ctrl_t              bundle,
  output logic               cond,
  output logic [REP_W_P-1:0] rep
);

  always_comb begin
    bundle      = '0;
    bundle.op   = instr.op;
    bundle.emit = instr.emit;
    bundle.wen  = instr.wen;
    bundle.wa   = instr.wa;
    bundle.raa  = instr.raa;
    bundle.rab  = instr.rab;
    bundle.sel  = SEL_W_P'(instr.sel);
    bundle.ctrl[CTRL_WSRC_BIT] = instr.wsrc;
  end

  assign cond = instr.cond;
  assign rep  = instr.rep;

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-instruction sequencer: accepts instructions, repeats them rep+1 cycles,
// squashes conditionals on the stored flag and captures datapath results.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 4,
  parameter int OUT_W  = 7,
  parameter int REP_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [23:0]       instr,
  input  logic              Flag,
  input  logic [OUT_W-1:0]  OutPort,
  output logic [SEL_W-1:0]  Sel,
  output logic              Wen,
  output logic [REG_AW-1:0] WA,
  output logic [REG_AW-1:0] RAA,
  output logic [REG_AW-1:0] RAB,
  output logic [2:0]        Op,
  output logic [7:0]        Ctrl,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy
);

  seq_state_e         state_r;
  seq_state_e         state_nxt_s;
  instr_t             instr_s;
  ctrl_t              dec_s;
  ctrl_t              cur_r;
  logic               cond_s;
  logic [REP_W_P-1:0] rep_s;
  logic [REP_W-1:0]   cnt_r;
  logic               squash_r;
  logic               flag_q_r;
  logic               res_valid_r;
  logic [OUT_W-1:0]   res_data_r;
  logic               exec_s;
  logic               last_s;
  logic               can_take_s;
  logic               accept_s;
  logic               flag_eff_s;
  logic               squash_nxt_s;

  assign instr_s = instr;

  instr_decode u_decode (
    .instr  (instr_s),
    .bundle (dec_s),
    .cond   (cond_s),
    .rep    (rep_s)
  );

  // Last-cycle detection and squash evaluation; a flag being retired this
  // cycle is forwarded so a back-to-back conditional sees it.
  always_comb begin
    exec_s     = (state_r == EXEC);
    last_s     = exec_s && ((cnt_r == {REP_W{1'b0}}) || squash_r);
    can_take_s = !exec_s || last_s;
    accept_s   = instr_valid && can_take_s;
    if (last_s && !squash_r) begin
      flag_eff_s = Flag;
    end else begin
      flag_eff_s = flag_q_r;
    end
    squash_nxt_s = cond_s && !flag_eff_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        if (last_s && !accept_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_r    <= '0;
      cnt_r    <= {REP_W{1'b0}};
      squash_r <= 1'b0;
    end else if (accept_s) begin
      cur_r    <= dec_s;
      cnt_r    <= rep_s;
      squash_r <= squash_nxt_s;
    end else if (exec_s && !last_s) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  // Flag retirement and result capture happen only for live (non-squashed) work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {OUT_W{1'b0}};
    end else begin
      if (last_s && !squash_r) begin
        flag_q_r <= Flag;
      end
      res_valid_r <= exec_s && !squash_r && cur_r.emit;
      if (exec_s && !squash_r && cur_r.emit) begin
        res_data_r <= OutPort;
      end
    end
  end

  always_comb begin
    Sel         = {SEL_W{1'b0}};
    Wen         = 1'b0;
    WA          = {REG_AW{1'b0}};
    RAA         = {REG_AW{1'b0}};
    RAB         = {REG_AW{1'b0}};
    Op          = 3'd0;
    Ctrl        = 8'd0;
    busy        = 1'b0;
    instr_ready = rst_n && can_take_s;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      EXEC: begin
        busy = 1'b1;
        Sel  = cur_r.sel;
        Wen  = cur_r.wen && !squash_r;
        WA   = cur_r.wa;
        RAA  = cur_r.raa;
        RAB  = cur_r.rab;
        Op   = cur_r.op;
        Ctrl = cur_r.ctrl;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control stage directly upstream of the 64-bit-in / 7-bit-out register-file datapath.
- Accepts a stream of 24-bit micro-instructions over a valid/ready handshake and decodes each one into the datapath control bundle: Sel, Wen, WA, RAA, RAB, Op, Ctrl.
- Consumes the datapath's Flag (conditional execution) and OutPort (result capture).
- Supports repeat counts for multi-step operations such as repeated shifts.

Parameters:
- REG_AW, 4, register-file address width (WA/RAA/RAB)
- SEL_W, 4, datapath byte-select width; only 0..7 are issued
- OUT_W, 7, datapath result width
- REP_W, 2, repeat-count field width; an instruction executes rep+1 cycles

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  24  micro-instruction
- Flag  in  1  datapath flag
- OutPort  in  OUT_W  datapath result
- Sel  out  SEL_W  input byte select
- Wen  out  1  register write enable
- WA  out  REG_AW  write address
- RAA  out  REG_AW  read address A
- RAB  out  REG_AW  read address B
- Op  out  3  ALU opcode
- Ctrl  out  8  datapath control; bit0 = write source (0 = InPort slice, 1 = ALU result); bits 7:1 = 0
- res_valid  out  1  one-cycle pulse; res_data valid
- res_data  out  OUT_W  captured OutPort
- busy  out  1  instruction executing

Behaviour:
- Instruction fields:
  - [23:21] op
  - [20] emit
  - [19] wen
  - [18] wsrc
  - [17:14] wa
  - [13:10] raa
  - [9:6] rab
  - [5:3] sel, zero-extended onto Sel
  - [2] cond
  - [1:0] rep
- Reset (async, rst_n=0):
  - state IDLE; instruction register, repeat counter, flag_q, res_valid and res_data = 0.
  - All control outputs = 0; instr_ready=0 while in reset.
  - Reset mid-instruction drops the instruction with no further Wen.
- FSM states:
  - IDLE: instr_ready=1, controls 0, busy=0. On instr_valid&instr_ready, latch instr, load cnt=rep, evaluate squash, go EXEC.
  - EXEC: busy=1. Controls are driven combinationally from the latched instruction. cnt decrements each cycle.
  - Last EXEC cycle is cnt==0, or squash=1.
  - instr_ready=1 in the last EXEC cycle. If a new instruction is accepted there, stay in EXEC with the new instruction (back-to-back, no bubble); otherwise go to IDLE.
- Latency: the first control cycle is the cycle after acceptance.
- Wen = wen & ~squash in each EXEC cycle.
  - With rep>0 every repetition writes. Software sets wa=raa for in-place iteration.
- Op, WA, RAA, RAB, Sel and Ctrl[0] are held constant for all repetitions of one instruction.
- Conditional execution:
  - squash = cond & ~flag_q, computed at acceptance.
  - A squashed instruction retires in exactly 1 EXEC cycle with Wen=0 and no capture, regardless of rep.
- flag_q: updated with Flag in the last EXEC cycle of every non-squashed instruction. Squashed instructions leave it unchanged.
- Capture: in each non-squashed EXEC cycle with emit=1, res_data <= OutPort and res_valid=1 in the next cycle. There is no backpressure, so rep>0 with emit yields rep+1 consecutive pulses.
- Simultaneous events: acceptance in the last EXEC cycle uses the flag_q value being written in that same cycle, i.e. the bypassed Flag, for squash evaluation.
- Op values other than MOV(4) and SHR(1) pass through unchanged; datapath semantics are out of scope here.

Decomposition:
- Package datapath_pkg holds:
  - op_e enum: OP_SHR=1, OP_MOV=4
  - instr_t packed struct matching the field list above
  - CTRL_WSRC_BIT=0
  - seq_state_e: IDLE, EXEC
- Sub-module instr_decode: combinational, instr_t -> control bundle. The FSM, counters, flag_q and capture stay in datapath_sequencer.

Test Plan:
- Load/move: instr {wen=1, wsrc=0, sel=2, wa=3} then {op=MOV, raa=3, emit=1}, InPort byte2=0x55 -> Wen=1, WA=3, Sel=2 in cycle 1; Op=4, RAA=3 in cycle 2; res_valid with res_data=0x55 in cycle 3.
- Repeat shift: {op=SHR, wen=1, wsrc=1, wa=3, raa=3, rep=3, emit=1} -> exactly 4 consecutive Wen cycles, 4 res_valid pulses, instr_ready low for 3 cycles, then high.
- Conditional squash: flag_q=0, {cond=1, wen=1, rep=2} -> one EXEC cycle, Wen never asserted, no res_valid, flag_q unchanged. Same instruction with flag_q=1 -> 3 Wen cycles.
- Back-to-back: instr_valid held high with 3 rep=0 instructions -> 3 consecutive EXEC cycles, busy continuously 1, no IDLE bubble.
- Reset mid-op: rst_n low during the second cycle of a rep=3 instruction -> Wen, busy, res_valid and all control outputs 0 immediately (async). After release, IDLE with instr_ready=1.
